// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, frame width and
// the sample-tick divider calculation.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    // clk cycles per oversample tick, rounded to nearest
    function automatic int unsigned calc_tick_div(
        input longint unsigned clk_freq,
        input longint unsigned baud,
        input longint unsigned oversample
    );
        longint unsigned den;
        den = baud * oversample;
        calc_tick_div = 32'((clk_freq + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-side handshake of the UART receiver: received data, valid/ack and
// line status flags.
interface uart_receiver_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ack;
    logic                 overrun;
    logic                 framing_error;
    logic                 busy;

    modport master (
        output data,
        output data_valid,
        output overrun,
        output framing_error,
        output busy,
        input  data_ack
    );

    modport slave (
        input  data,
        input  data_valid,
        input  overrun,
        input  framing_error,
        input  busy,
        output data_ack
    );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// Free-running oversample tick generator: one-clk tick every TICK_DIV clks,
// independent of line activity.
module uart_rx_tick_gen #(
    parameter int unsigned TICK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = w_wrap;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: synchronises RxD, oversamples it, checks start and
// first stop bit, and hands bytes out through a valid/ack handshake.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RxD,
    uart_receiver_if.master rx_if
);

    localparam int unsigned TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned OS_W     = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W    = $clog2(DATA_BITS);

    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic r_sync1;
    logic r_rx_s;
    logic w_tick;

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic [OS_W-1:0]      r_os_cnt;
    logic [OS_W-1:0]      w_os_nxt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_commit;
    logic                 w_frame_err;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 r_frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_rx_s  <= r_sync1;
        end
    end

    uart_rx_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_os_cnt  <= w_os_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_os_nxt    = r_os_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_commit    = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !r_rx_s) begin
                    w_state_nxt = ST_START;
                    w_os_nxt    = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_os_cnt == OS_MID) begin
                        // a start bit that is high again at its midpoint is a glitch
                        if (!r_rx_s) begin
                            w_state_nxt = ST_DATA;
                            w_os_nxt    = '0;
                            w_bit_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_os_cnt == OS_LAST) begin
                        w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                        w_os_nxt    = '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_os_cnt == OS_LAST) begin
                        // leaving at mid stop bit leaves half a bit to catch the next start edge
                        w_os_nxt = '0;
                        if (r_rx_s) begin
                            w_commit    = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_frame_err = 1'b1;
                            w_state_nxt = ST_WAIT_HIGH;
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (r_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // a commit in the same cycle as an ack takes priority over the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            if (w_commit) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid && !rx_if.data_ack) begin
                    r_overrun <= 1'b1;
                end else if (r_valid && rx_if.data_ack) begin
                    r_overrun <= 1'b0;
                end
            end else if (rx_if.data_ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_if.data          = r_data;
    assign rx_if.data_valid    = r_valid;
    assign rx_if.overrun       = r_overrun;
    assign rx_if.framing_error = r_frame_err;
    assign rx_if.busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomized
// frames checked against a byte-level model of the receiver's outcomes.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int unsigned BAUD     = 115200;
    localparam int unsigned OS       = 16;
    localparam int unsigned CLK_FREQ = BAUD * OS * 4;
    localparam int unsigned BCLK     = 64;

    logic clk = 1'b0;
    logic reset;
    logic RxD;

    uart_receiver_if u_if ();

    uart_receiver #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .RxD  (RxD),
        .rx_if(u_if)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned ferr_seen = 0;
    int unsigned rise_cyc  = 0;
    logic        prev_valid = 1'b0;
    bit          watch_gap  = 1'b0;
    int unsigned gap_cnt    = 0;

    always @(negedge clk) begin
        if (u_if.framing_error === 1'b1) ferr_seen++;
        if (u_if.data_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
        prev_valid = u_if.data_valid;
        if (watch_gap && u_if.data_valid !== 1'b1) gap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int unsigned n);
        RxD = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input int unsigned nstop, input int unsigned bclk);
        drive_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_bit(b[i], bclk);
        drive_bit(stop_ok, bclk);
        for (int unsigned i = 1; i < nstop; i++) drive_bit(1'b1, bclk);
    endtask

    task automatic ack_pulse();
        u_if.data_ack = 1'b1;
        @(negedge clk);
        u_if.data_ack = 1'b0;
        @(negedge clk);
    endtask

    // byte-level model: what the consumer should see after each whole frame
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ovr;
    int unsigned m_ferr;

    int unsigned s1, s2, c1, target, guard, ferr_base, gap;
    bit          hit;
    logic [7:0]  rb, pb;
    bit          rok;
    int unsigned rstop, rbclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RxD = 1'b1;
        u_if.data_ack = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data",  u_if.data, 8'h00);
        chk("rst_valid", u_if.data_valid, 1'b0);
        chk("rst_ovr",   u_if.overrun, 1'b0);
        chk("rst_ferr",  u_if.framing_error, 1'b0);
        chk("rst_busy",  u_if.busy, 1'b0);
        reset = 1'b0;
        idle(BCLK);

        // single frame
        send_frame(8'hA5, 1'b1, 1, BCLK);
        idle(BCLK);
        chk("a5_data",  u_if.data, 8'hA5);
        chk("a5_valid", u_if.data_valid, 1'b1);
        chk("a5_ferr",  ferr_seen, 0);
        chk("a5_ovr",   u_if.overrun, 1'b0);
        idle(3 * BCLK);
        chk("a5_hold",  u_if.data_valid, 1'b1);
        ack_pulse();
        chk("a5_ack",   u_if.data_valid, 1'b0);
        chk("a5_keep",  u_if.data, 8'hA5);

        // start-bit glitch of 3 ticks
        RxD = 1'b0;
        repeat (8) @(negedge clk);
        chk("gl_busy_on", u_if.busy, 1'b1);
        repeat (4) @(negedge clk);
        RxD = 1'b1;
        repeat (32) @(negedge clk);
        chk("gl_busy_off", u_if.busy, 1'b0);
        chk("gl_valid",    u_if.data_valid, 1'b0);
        idle(BCLK);

        // framing error, line held low (break)
        ferr_base = ferr_seen;
        send_frame(8'h3C, 1'b0, 1, BCLK);
        drive_bit(1'b0, BCLK);
        chk("fe_pulses", ferr_seen - ferr_base, 1);
        chk("fe_data",   u_if.data, 8'hA5);
        chk("fe_valid",  u_if.data_valid, 1'b0);
        chk("fe_busy",   u_if.busy, 1'b1);
        RxD = 1'b1;
        repeat (4) @(negedge clk);
        chk("fe_release", u_if.busy, 1'b0);
        idle(BCLK);
        send_frame(8'h55, 1'b1, 1, BCLK);
        idle(BCLK);
        chk("fe_next_data",  u_if.data, 8'h55);
        chk("fe_next_valid", u_if.data_valid, 1'b1);
        chk("fe_next_ferr",  ferr_seen - ferr_base, 1);
        ack_pulse();

        // back-to-back frames without ack
        send_frame(8'h11, 1'b1, 1, BCLK);
        send_frame(8'h22, 1'b1, 1, BCLK);
        idle(BCLK);
        chk("ov_data",  u_if.data, 8'h22);
        chk("ov_valid", u_if.data_valid, 1'b1);
        chk("ov_flag",  u_if.overrun, 1'b1);
        ack_pulse();
        chk("ov_ack_valid", u_if.data_valid, 1'b0);
        chk("ov_ack_flag",  u_if.overrun, 1'b0);

        // ack landing on the commit cycle of the next byte
        s1 = cyc;
        send_frame(8'h66, 1'b1, 1, BCLK);
        idle(BCLK);
        c1 = rise_cyc;
        chk("ca_first", u_if.data, 8'h66);
        s2 = cyc;
        target = c1 + (s2 - s1);
        gap_cnt = 0;
        watch_gap = 1'b1;
        hit = 1'b0;
        fork
            send_frame(8'h77, 1'b1, 1, BCLK);
            begin
                guard = 0;
                while (cyc != target - 1 && guard < 4000) begin
                    @(negedge clk);
                    guard++;
                end
                if (cyc == target - 1) hit = 1'b1;
                u_if.data_ack = 1'b1;
                @(negedge clk);
                u_if.data_ack = 1'b0;
            end
        join
        idle(BCLK);
        watch_gap = 1'b0;
        chk("ca_sched", hit, 1'b1);
        chk("ca_gap",   gap_cnt, 0);
        chk("ca_data",  u_if.data, 8'h77);
        chk("ca_valid", u_if.data_valid, 1'b1);
        chk("ca_ovr",   u_if.overrun, 1'b0);
        ack_pulse();

        // reset during data bit 4
        pb = 8'h96;
        drive_bit(1'b0, BCLK);
        for (int i = 0; i < 4; i++) drive_bit(pb[i], BCLK);
        drive_bit(pb[4], BCLK / 2);
        chk("mr_busy_pre", u_if.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_data",  u_if.data, 8'h00);
        chk("mr_valid", u_if.data_valid, 1'b0);
        chk("mr_ovr",   u_if.overrun, 1'b0);
        chk("mr_ferr",  u_if.framing_error, 1'b0);
        chk("mr_busy",  u_if.busy, 1'b0);
        RxD = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        idle(2 * BCLK);
        ferr_base = ferr_seen;
        send_frame(8'hC3, 1'b1, 1, BCLK);
        idle(BCLK);
        chk("mr_next_data",  u_if.data, 8'hC3);
        chk("mr_next_valid", u_if.data_valid, 1'b1);
        chk("mr_next_ferr",  ferr_seen - ferr_base, 0);
        ack_pulse();

        // loopback-style two stop bits, and +/-3% baud mismatch
        send_frame(8'h5A, 1'b1, 2, BCLK);
        chk("lb_data",  u_if.data, 8'h5A);
        chk("lb_valid", u_if.data_valid, 1'b1);
        chk("lb_ferr",  ferr_seen - ferr_base, 0);
        ack_pulse();
        send_frame(8'hE7, 1'b1, 1, 62);
        idle(BCLK);
        chk("fast_data", u_if.data, 8'hE7);
        ack_pulse();
        send_frame(8'h18, 1'b1, 1, 66);
        idle(BCLK);
        chk("slow_data", u_if.data, 8'h18);
        chk("tol_ferr",  ferr_seen - ferr_base, 0);
        ack_pulse();

        // randomized frames against the byte-level model
        m_data  = u_if.data;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = ferr_seen;
        for (int it = 0; it < 24; it++) begin
            rb    = 8'($urandom);
            rok   = ($urandom_range(0, 5) != 0);
            rstop = $urandom_range(1, 2);
            rbclk = $urandom_range(62, 66);
            gap   = $urandom_range(0, 2);
            if (!rok && gap == 0) gap = 1;
            send_frame(rb, rok, rstop, rbclk);
            if (rok) begin
                if (m_valid) m_ovr = 1'b1;
                m_data  = rb;
                m_valid = 1'b1;
            end else begin
                m_ferr++;
            end
            idle(gap * rbclk);
            chk("rnd_data",  u_if.data, m_data);
            chk("rnd_valid", u_if.data_valid, m_valid);
            chk("rnd_ovr",   u_if.overrun, m_ovr);
            chk("rnd_ferr",  ferr_seen, m_ferr);
            if (gap > 0 && $urandom_range(0, 1) == 1) begin
                ack_pulse();
                m_valid = 1'b0;
                m_ovr   = 1'b0;
                chk("rnd_ack", u_if.data_valid, m_valid);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
